// File: rtl/svc_sram_cmd_mem.sv
// Single-port SRAM with a valid/ready command port and a credit-managed,
// in-order read response FIFO. Reads have a fixed pipeline latency of RD_LATENCY.
module svc_sram_cmd_mem #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned META_WIDTH = 4,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sram_cmd_valid,
  output logic                  sram_cmd_ready,
  input  logic                  sram_cmd_wr_en,
  input  logic [ADDR_WIDTH-1:0] sram_cmd_addr,
  input  logic [META_WIDTH-1:0] sram_cmd_meta,
  input  logic                  sram_cmd_last,
  input  logic [DATA_WIDTH-1:0] sram_cmd_wr_data,
  input  logic [STRB_WIDTH-1:0] sram_cmd_wr_strb,
  output logic                  sram_resp_valid,
  input  logic                  sram_resp_ready,
  output logic [META_WIDTH-1:0] sram_resp_meta,
  output logic                  sram_resp_last,
  output logic [DATA_WIDTH-1:0] sram_resp_rd_data
);

  localparam int unsigned MEM_DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned ENT_W     = META_WIDTH + 1 + DATA_WIDTH;
  localparam int unsigned PIPE_N    = (RD_LATENCY > 1) ? RD_LATENCY - 1 : 1;
  localparam int unsigned CNT_W     = $clog2(RESP_DEPTH + 1);
  localparam int unsigned SUM_W     = CNT_W + 1;
  localparam int unsigned PTR_W     = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic              cmd_ready_q, cmd_ready_d;
  logic              cmd_go, rd_acc, wr_acc;
  logic [ENT_W-1:0]  rd_ent;

  logic [PIPE_N-1:0] pvld_q, pvld_d;
  logic [ENT_W-1:0]  pent_q [PIPE_N];
  logic [ENT_W-1:0]  pent_d [PIPE_N];

  logic              push, pop;
  logic [ENT_W-1:0]  push_ent;
  logic [ENT_W-1:0]  fifo_q [RESP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d, count_rem;
  logic [CNT_W-1:0]  inflight_q, inflight_d;

  logic              resp_valid_q, resp_valid_d;
  logic [ENT_W-1:0]  resp_ent_q, resp_ent_d;

  assign sram_cmd_ready    = cmd_ready_q;
  assign sram_resp_valid   = resp_valid_q;
  assign sram_resp_rd_data = resp_ent_q[DATA_WIDTH-1:0];
  assign sram_resp_last    = resp_ent_q[DATA_WIDTH];
  assign sram_resp_meta    = resp_ent_q[ENT_W-1 -: META_WIDTH];

  // Command decode and array read port
  always_comb begin
    cmd_go = sram_cmd_valid & cmd_ready_q & rst_n;
    rd_acc = cmd_go & ~sram_cmd_wr_en;
    wr_acc = cmd_go & sram_cmd_wr_en;
    rd_ent = {sram_cmd_meta, sram_cmd_last, mem[sram_cmd_addr]};
  end

  // Byte-masked write; the array itself is never reset
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (sram_cmd_wr_strb[b]) begin
          mem[sram_cmd_addr][b*8 +: 8] <= sram_cmd_wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Read pipeline shift, FIFO bookkeeping and credit computation
  always_comb begin
    pvld_d[0] = rd_acc;
    pent_d[0] = rd_ent;
    for (int k = 1; k < PIPE_N; k++) begin
      pvld_d[k] = pvld_q[k-1];
      pent_d[k] = pent_q[k-1];
    end

    if (RD_LATENCY == 1) begin
      push       = rd_acc;
      push_ent   = rd_ent;
      inflight_d = '0;
    end else begin
      push       = pvld_q[PIPE_N-1];
      push_ent   = pent_q[PIPE_N-1];
      inflight_d = inflight_q + CNT_W'(rd_acc) - CNT_W'(push);
    end

    pop       = resp_valid_q & sram_resp_ready;
    wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_rem = count_q - CNT_W'(pop);
    count_d   = count_rem + CNT_W'(push);

    // Head register: bypass the entry being pushed when the FIFO drains empty
    resp_valid_d = (count_d != '0);
    if (count_d == '0) begin
      resp_ent_d = '0;
    end else if (count_rem == '0) begin
      resp_ent_d = push_ent;
    end else begin
      resp_ent_d = fifo_q[rd_ptr_d];
    end

    cmd_ready_d = (SUM_W'(inflight_d) + SUM_W'(count_d)) < SUM_W'(RESP_DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready_q  <= 1'b1;
      pvld_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      inflight_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_ent_q   <= '0;
    end else begin
      cmd_ready_q  <= cmd_ready_d;
      pvld_q       <= pvld_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      resp_valid_q <= resp_valid_d;
      resp_ent_q   <= resp_ent_d;
    end
  end

  // Payload storage carries no reset; validity is tracked separately
  always_ff @(posedge clk) begin
    for (int k = 0; k < PIPE_N; k++) begin
      pent_q[k] <= pent_d[k];
    end
    if (push) begin
      fifo_q[wr_ptr_q] <= push_ent;
    end
  end

endmodule

// File: tb/tb_svc_sram_cmd_mem.sv
// Directed and constrained-random bench for svc_sram_cmd_mem with a
// negedge response monitor checking order, payload and stall stability.
module tb_svc_sram_cmd_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sram_cmd_valid, sram_cmd_ready, sram_cmd_wr_en, sram_cmd_last;
  logic [9:0]  sram_cmd_addr;
  logic [3:0]  sram_cmd_meta;
  logic [15:0] sram_cmd_wr_data;
  logic [1:0]  sram_cmd_wr_strb;
  logic        sram_resp_valid, sram_resp_ready, sram_resp_last;
  logic [3:0]  sram_resp_meta;
  logic [15:0] sram_resp_rd_data;

  always #5 clk = ~clk;

  svc_sram_cmd_mem dut (
    .clk(clk), .rst_n(rst_n),
    .sram_cmd_valid(sram_cmd_valid), .sram_cmd_ready(sram_cmd_ready),
    .sram_cmd_wr_en(sram_cmd_wr_en), .sram_cmd_addr(sram_cmd_addr),
    .sram_cmd_meta(sram_cmd_meta), .sram_cmd_last(sram_cmd_last),
    .sram_cmd_wr_data(sram_cmd_wr_data), .sram_cmd_wr_strb(sram_cmd_wr_strb),
    .sram_resp_valid(sram_resp_valid), .sram_resp_ready(sram_resp_ready),
    .sram_resp_meta(sram_resp_meta), .sram_resp_last(sram_resp_last),
    .sram_resp_rd_data(sram_resp_rd_data)
  );

  typedef struct {
    logic [15:0] d;
    logic [3:0]  m;
    logic        l;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  int          pop_cnt  = 0;
  exp_t        expq [$];
  logic [15:0] ref_mem [int];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, waiting (bounded) for ready; updates the reference model
  task automatic do_cmd(input logic wr, input logic [9:0] addr, input logic [15:0] data,
                        input logic [1:0] strb, input logic [3:0] meta, input logic last);
    int   n;
    exp_t e;
    logic [15:0] w;
    sram_cmd_valid   = 1'b1;
    sram_cmd_wr_en   = wr;
    sram_cmd_addr    = addr;
    sram_cmd_wr_data = data;
    sram_cmd_wr_strb = strb;
    sram_cmd_meta    = meta;
    sram_cmd_last    = last;
    n = 0;
    while (!sram_cmd_ready && n < 100) begin
      if (n > 20) sram_resp_ready = 1'b1;
      cyc();
      n++;
    end
    if (!sram_cmd_ready) begin
      check("cmd_ready_timeout", 32'(sram_cmd_ready), 32'd1);
      sram_cmd_valid = 1'b0;
      return;
    end
    cyc();
    if (wr) begin
      w = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 16'h0000;
      if (strb[0]) w[7:0]  = data[7:0];
      if (strb[1]) w[15:8] = data[15:8];
      ref_mem[int'(addr)] = w;
    end else begin
      e.d = ref_mem[int'(addr)];
      e.m = meta;
      e.l = last;
      expq.push_back(e);
    end
    sram_cmd_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (!sram_resp_valid && n < 20) begin
      cyc();
      n++;
    end
    check("resp_wait", 32'(sram_resp_valid), 32'd1);
  endtask

  // Response monitor: in-order payload check and stability under backpressure
  logic        prev_stall = 1'b0;
  logic [21:0] prev_out;
  exp_t        me;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall)
        check("hold", 32'({sram_resp_valid, sram_resp_meta, sram_resp_last, sram_resp_rd_data}),
              32'(prev_out));
      if (sram_resp_valid && sram_resp_ready) begin
        if (expq.size() == 0) begin
          check("spurious_resp", 32'd1, 32'd0);
        end else begin
          me = expq.pop_front();
          check("resp_data", 32'(sram_resp_rd_data), 32'(me.d));
          check("resp_meta", 32'(sram_resp_meta), 32'(me.m));
          check("resp_last", 32'(sram_resp_last), 32'(me.l));
        end
        pop_cnt++;
      end
      prev_stall = sram_resp_valid && !sram_resp_ready;
      prev_out   = {sram_resp_valid, sram_resp_meta, sram_resp_last, sram_resp_rd_data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int p0;
    int n;
    rst_n = 1'b0;
    sram_cmd_valid = 1'b0; sram_cmd_wr_en = 1'b0; sram_cmd_addr = '0;
    sram_cmd_meta = '0; sram_cmd_last = 1'b0; sram_cmd_wr_data = '0;
    sram_cmd_wr_strb = '0; sram_resp_ready = 1'b1;

    // Reset values
    repeat (3) cyc();
    check("rst_valid", 32'(sram_resp_valid), 32'd0);
    check("rst_meta", 32'(sram_resp_meta), 32'd0);
    check("rst_last", 32'(sram_resp_last), 32'd0);
    check("rst_data", 32'(sram_resp_rd_data), 32'd0);
    rst_n = 1'b1;
    check("rst_ready0", 32'(sram_cmd_ready), 32'd1);
    cyc();
    check("rst_ready1", 32'(sram_cmd_ready), 32'd1);

    // Write then read next cycle; exact 2-cycle latency
    do_cmd(1'b1, 10'h005, 16'hBEEF, 2'b11, 4'h0, 1'b0);
    do_cmd(1'b0, 10'h005, 16'h0000, 2'b00, 4'h3, 1'b1);
    check("lat_n1_valid", 32'(sram_resp_valid), 32'd0);
    cyc();
    check("lat_n2_valid", 32'(sram_resp_valid), 32'd1);
    check("lat_n2_data", 32'(sram_resp_rd_data), 32'hBEEF);
    check("lat_n2_meta", 32'(sram_resp_meta), 32'h3);
    check("lat_n2_last", 32'(sram_resp_last), 32'd1);
    cyc();
    check("lat_popped", 32'(sram_resp_valid), 32'd0);

    // Byte strobes, including all-zero strobe
    do_cmd(1'b1, 10'h010, 16'hAAAA, 2'b11, 4'h0, 1'b0);
    do_cmd(1'b1, 10'h010, 16'h5555, 2'b01, 4'h0, 1'b0);
    do_cmd(1'b0, 10'h010, 16'h0000, 2'b00, 4'h5, 1'b0);
    wait_resp();
    check("strb_lo", 32'(sram_resp_rd_data), 32'hAA55);
    cyc();
    do_cmd(1'b1, 10'h010, 16'hFFFF, 2'b00, 4'h0, 1'b0);
    do_cmd(1'b0, 10'h010, 16'h0000, 2'b00, 4'h6, 1'b0);
    wait_resp();
    check("strb_none", 32'(sram_resp_rd_data), 32'hAA55);
    cyc();

    for (int i = 0; i < 8; i++)
      do_cmd(1'b1, 10'(32'h20 + i), 16'(32'h1000 + i * 32'h111), 2'b11, 4'h0, 1'b0);

    // Backpressure: four credits, then ready drops and the head holds
    sram_resp_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      do_cmd(1'b0, 10'(32'h20 + i), 16'h0, 2'b00, 4'(i), 1'b0);
    check("full_ready_now", 32'(sram_cmd_ready), 32'd0);
    sram_cmd_valid = 1'b1; sram_cmd_wr_en = 1'b0; sram_cmd_addr = 10'h024;
    sram_cmd_meta = 4'h9;
    repeat (3) begin
      cyc();
      check("full_ready", 32'(sram_cmd_ready), 32'd0);
      check("full_head_data", 32'(sram_resp_rd_data), 32'h1000);
      check("full_head_meta", 32'(sram_resp_meta), 32'h0);
    end
    sram_cmd_valid = 1'b0;
    p0 = pop_cnt;
    sram_resp_ready = 1'b1;
    repeat (4) cyc();
    check("drain_pops", 32'(pop_cnt - p0), 32'd4);
    check("drain_valid", 32'(sram_resp_valid), 32'd0);
    check("drain_ready", 32'(sram_cmd_ready), 32'd1);

    // Eight-read burst at full throughput
    p0 = pop_cnt;
    for (int i = 0; i < 8; i++)
      do_cmd(1'b0, 10'(32'h20 + i), 16'h0, 2'b00, 4'(i), (i == 7));
    repeat (2) cyc();
    check("burst_pops", 32'(pop_cnt - p0), 32'd8);
    check("burst_idle", 32'(sram_resp_valid), 32'd0);

    // Reset with reads in flight
    sram_resp_ready = 1'b0;
    do_cmd(1'b0, 10'h020, 16'h0, 2'b00, 4'h1, 1'b0);
    do_cmd(1'b0, 10'h021, 16'h0, 2'b00, 4'h2, 1'b0);
    check("pre_rst_valid", 32'(sram_resp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(sram_resp_valid), 32'd0);
    check("mid_rst_data", 32'(sram_resp_rd_data), 32'd0);
    check("mid_rst_meta", 32'(sram_resp_meta), 32'd0);
    expq.delete();
    repeat (2) cyc();
    rst_n = 1'b1;
    sram_resp_ready = 1'b1;
    p0 = pop_cnt;
    repeat (5) cyc();
    check("post_rst_pops", 32'(pop_cnt - p0), 32'd0);
    check("post_rst_valid", 32'(sram_resp_valid), 32'd0);
    check("post_rst_ready", 32'(sram_cmd_ready), 32'd1);
    do_cmd(1'b0, 10'h010, 16'h0, 2'b00, 4'h7, 1'b0);
    wait_resp();
    check("post_rst_mem10", 32'(sram_resp_rd_data), 32'hAA55);
    cyc();
    do_cmd(1'b0, 10'h005, 16'h0, 2'b00, 4'h8, 1'b1);
    wait_resp();
    check("post_rst_mem05", 32'(sram_resp_rd_data), 32'hBEEF);
    cyc();

    // Random mix against the reference model
    for (int i = 0; i < 8; i++)
      do_cmd(1'b1, 10'(32'h40 + i), 16'($urandom), 2'b11, 4'h0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      sram_resp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0)
        do_cmd(1'b1, 10'(32'h40 + $urandom_range(0, 7)), 16'($urandom),
               2'($urandom_range(0, 3)), 4'h0, 1'b0);
      else
        do_cmd(1'b0, 10'(32'h40 + $urandom_range(0, 7)), 16'h0, 2'b00,
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) cyc();
    end
    sram_resp_ready = 1'b1;
    n = 0;
    while (expq.size() > 0 && n < 200) begin
      cyc();
      n++;
    end
    check("rand_drain", 32'(expq.size()), 32'd0);
    cyc();
    check("rand_idle", 32'(sram_resp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
